// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST.
// Bit i of each ELEM_* vector describes March element i.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int ELEM_W = 3;
  localparam logic [ELEM_W-1:0] ELEM_LAST = 3'd5;

  // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0)
  // E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO    = 8'b0001_1110;
  localparam logic [7:0] ELEM_READ   = 8'b0011_1110;
  localparam logic [7:0] ELEM_RD_ONE = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_ONE = 8'b0000_1010;

endpackage

// File: rtl/sram_march_bist_if.sv
// Macro-side pins of the single-port SRAM.
// master drives csb0/web0/addr0/din0 and receives dout0.
interface sram_march_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;

  modport master (
    output csb0, web0, addr0, din0,
    input  dout0
  );

  modport slave (
    input  csb0, web0, addr0, din0,
    output dout0
  );
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for March elements.
// Ports: clk, rstb, load (with down), step, addr, last.
module sram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  load,
  input  logic                  down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX =
    ADDR_WIDTH'(RAM_DEPTH - 1);

  logic down_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      down_q <= down;
      addr   <= down ? ADDR_MAX : '0;
    end else if (step) begin
      addr <= down_q ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down_q ? (addr == '0) : (addr == ADDR_MAX);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller in front of a 1RW SRAM macro.
// Ports: clk0/rstb0, start, func_* passthrough, mem (macro), status.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  start,
  input  logic                  func_csb0,
  input  logic                  func_web0,
  input  logic [ADDR_WIDTH-1:0] func_addr0,
  input  logic [DATA_WIDTH-1:0] func_din0,
  sram_march_bist_if.master     mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ELEM_W-1:0]     fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  state_t state_q, state_d;

  logic [ELEM_W-1:0]     elem_q, elem_d, nxt_elem;
  logic                  phase_q, phase_d, nxt_phase;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  issue;
  logic                  ag_load, ag_down, ag_step, ag_last;
  logic [ADDR_WIDTH-1:0] ag_addr;
  logic                  last_phase, acc_start, mismatch;
  logic                  fail_q;

  logic                  cmp_vld_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic [ELEM_W-1:0]     cmp_elem_q;

  sram_bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_addr_gen (
    .clk  (clk0),
    .rstb (rstb0),
    .load (ag_load),
    .down (ag_down),
    .step (ag_step),
    .addr (ag_addr),
    .last (ag_last)
  );

  assign last_phase = !ELEM_TWO[elem_q] || phase_q;
  assign acc_start  = start &&
    (state_q == IDLE || state_q == DONE);
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign mismatch = cmp_vld_q && (mem.dout0 != cmp_exp_q);

  // Sequencer: the op held in csb/web/din/addr is the one the
  // macro samples on the next edge; here we pick the op after it.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    csb_d     = csb_q;
    web_d     = web_q;
    din_d     = din_q;
    nxt_elem  = elem_q;
    nxt_phase = phase_q;
    issue     = 1'b0;
    ag_load   = 1'b0;
    ag_down   = 1'b0;
    ag_step   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          nxt_elem  = '0;
          nxt_phase = 1'b0;
          ag_load   = 1'b1;
          issue     = 1'b1;
        end
      end
      RUN: begin
        if (!last_phase) begin
          nxt_phase = 1'b1;
          issue     = 1'b1;
        end else if (!ag_last) begin
          ag_step   = 1'b1;
          nxt_phase = 1'b0;
          issue     = 1'b1;
        end else if (elem_q == ELEM_LAST) begin
          state_d = DRAIN;
          csb_d   = 1'b1;
          web_d   = 1'b1;
        end else begin
          nxt_elem  = elem_q + 3'd1;
          nxt_phase = 1'b0;
          ag_load   = 1'b1;
          issue     = 1'b1;
        end
      end
      DRAIN: state_d = DONE;
    endcase
    if (issue) begin
      elem_d  = nxt_elem;
      phase_d = nxt_phase;
      ag_down = ELEM_DOWN[nxt_elem];
      csb_d   = 1'b0;
      web_d   = ELEM_READ[nxt_elem] && !nxt_phase;
      din_d   = {DATA_WIDTH{ELEM_WR_ONE[nxt_elem]}};
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      phase_q    <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      din_q      <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
      fail_q     <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_data  <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      phase_q    <= phase_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      din_q      <= din_d;
      // The read sampled by the macro on this edge is checked
      // on the next one.
      cmp_vld_q  <= (state_q == RUN) && !csb_q && web_q;
      cmp_exp_q  <= {DATA_WIDTH{ELEM_RD_ONE[elem_q]}};
      cmp_addr_q <= ag_addr;
      cmp_elem_q <= elem_q;
      if (acc_start) begin
        fail_q    <= 1'b0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else begin
        if (mismatch && !fail_q) begin
          fail_q    <= 1'b1;
          fail_addr <= cmp_addr_q;
          fail_elem <= cmp_elem_q;
          fail_data <= mem.dout0;
        end
        if (state_q == DRAIN) begin
          pass <= !(fail_q || mismatch);
        end
      end
    end
  end

  always_comb begin
    if (busy) begin
      mem.csb0  = csb_q;
      mem.web0  = web_q;
      mem.addr0 = ag_addr;
      mem.din0  = din_q;
    end else begin
      mem.csb0  = func_csb0;
      mem.web0  = func_web0;
      mem.addr0 = func_addr0;
      mem.din0  = func_din0;
    end
  end

endmodule
